// File: rtl/background_gen.sv
// rtl/background_gen.sv - two-stage playfield background colour pipeline for the VGA path.
// Optional water shimmer animation enabled by defining BG_WATER_ANIM_EN.
module background_gen #(
    parameter int X_LEFT     = 96,
    parameter int X_RIGHT    = 544,
    parameter int BLK_LOG2   = 5,
    parameter int END_ROW    = 0,
    parameter int RIVER_TOP  = 1,
    parameter int RIVER_BOT  = 7,
    parameter int GRASS0_ROW = 7,
    parameter int GRASS1_ROW = 14,
    parameter int ANIM_DIV   = 8,
    parameter int PHASE_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       freeze,
    input  logic       pix_valid,
    input  logic       on,
    input  logic [9:0] colPos,
    input  logic [9:0] rowPos,
    output logic [5:0] color,
    output logic       color_valid
);

    localparam logic [9:0] XL   = 10'(X_LEFT);
    localparam logic [9:0] XR   = 10'(X_RIGHT);
    localparam logic [9:0] ER   = 10'(END_ROW);
    localparam logic [9:0] RT   = 10'(RIVER_TOP);
    localparam logic [9:0] RB   = 10'(RIVER_BOT);
    localparam logic [9:0] G0   = 10'(GRASS0_ROW);
    localparam logic [9:0] G1   = 10'(GRASS1_ROW);
    localparam logic [5:0] BLACK = 6'b000000;
    localparam logic [5:0] BLUE  = 6'b000011;
    localparam logic [5:0] HILITE = 6'b010111;

    logic       s1_valid_q, s1_valid_d;
    logic       s1_on_q, s1_on_d;
    logic       s1_end_q, s1_end_d;
    logic       s1_river_q, s1_river_d;
    logic       s1_grass_q, s1_grass_d;
    logic [2:0] s1_p4_q, s1_p4_d;
    logic [2:0] s1_p8_q, s1_p8_d;
    logic [5:0] color_q, color_d;
    logic       color_valid_q, color_valid_d;

    logic [9:0] blk;
    logic       in_x;
    logic [9:0] col_s;

`ifdef BG_WATER_ANIM_EN
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        if (frame_start && !freeze) begin
            if (div_cnt_q == DIV_W'(ANIM_DIV - 1)) begin
                div_cnt_d = '0;
                phase_d   = phase_q + 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            phase_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
        end
    end

    // Pixel coincident with a pulse sees the registered (old) phase
    assign col_s = colPos + 10'({phase_q, 3'b000});
`else
    logic unused_anim;
    assign unused_anim = &{1'b0, frame_start, freeze};
    assign col_s = colPos;
`endif

    assign blk  = rowPos >> BLK_LOG2;
    assign in_x = (colPos >= XL) && (colPos < XR);

    always_comb begin
        s1_valid_d = pix_valid;
        s1_on_d    = pix_valid && on;
        s1_end_d   = in_x && (blk == ER);
        s1_river_d = in_x && (blk >= RT) && (blk < RB);
        s1_grass_d = in_x && ((blk == G0) || (blk == G1));
        s1_p4_d    = {colPos[2] ^ rowPos[2], colPos[3] ^ rowPos[4], colPos[4] ^ rowPos[3]};
        s1_p8_d    = {col_s[3] ^ rowPos[3], col_s[4] ^ rowPos[5], col_s[5] ^ rowPos[4]};
    end

    always_comb begin
        color_valid_d = s1_valid_q;
        color_d       = BLACK;
        if (s1_on_q) begin
            if (s1_end_q) begin
                case (s1_p4_q)
                    3'b000:  color_d = 6'b001000;
                    3'b001:  color_d = 6'b001001;
                    3'b010:  color_d = 6'b011000;
                    3'b011:  color_d = 6'b110001;
                    3'b100:  color_d = 6'b011110;
                    3'b111:  color_d = 6'b110001;
                    default: color_d = 6'b001000;
                endcase
            end else if (s1_river_q) begin
`ifdef BG_WATER_ANIM_EN
                color_d = (s1_p8_q == 3'b000) ? HILITE : BLUE;
`else
                color_d = (&{1'b1, s1_p8_q} | 1'b1) ? BLUE : HILITE;
`endif
            end else if (s1_grass_q) begin
                case (s1_p4_q)
                    3'b001, 3'b011: color_d = 6'b100000;
                    3'b101, 3'b010: color_d = 6'b010000;
                    default:        color_d = 6'b010001;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_on_q       <= 1'b0;
            s1_end_q      <= 1'b0;
            s1_river_q    <= 1'b0;
            s1_grass_q    <= 1'b0;
            s1_p4_q       <= 3'b000;
            s1_p8_q       <= 3'b000;
            color_q       <= BLACK;
            color_valid_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_on_q       <= s1_on_d;
            s1_end_q      <= s1_end_d;
            s1_river_q    <= s1_river_d;
            s1_grass_q    <= s1_grass_d;
            s1_p4_q       <= s1_p4_d;
            s1_p8_q       <= s1_p8_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
        end
    end

    assign color       = color_q;
    assign color_valid = color_valid_q;

endmodule

// File: tb/tb_background_gen.sv
// tb/tb_background_gen.sv - directed self-checking bench for background_gen.
// Water animation checks follow BG_WATER_ANIM_EN when it is defined.
module tb_background_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       freeze;
    logic       pix_valid;
    logic       on;
    logic [9:0] colPos;
    logic [9:0] rowPos;
    logic [5:0] color;
    logic       color_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] BLACK  = 6'b000000;
    localparam logic [5:0] BLUE   = 6'b000011;
    localparam logic [5:0] HILITE = 6'b010111;

`ifdef BG_WATER_ANIM_EN
    localparam logic [5:0] W_PH0 = HILITE;
    localparam logic [5:0] W_PH1 = BLUE;
`else
    localparam logic [5:0] W_PH0 = BLUE;
    localparam logic [5:0] W_PH1 = BLUE;
`endif

    background_gen dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .freeze(freeze),
        .pix_valid(pix_valid), .on(on), .colPos(colPos), .rowPos(rowPos),
        .color(color), .color_valid(color_valid)
    );

    always #5 clk = ~clk;

    task automatic check6(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one pixel at a negedge; result must appear exactly two edges later.
    task automatic check_pix(input string tag, input int col, input int row,
                             input logic onv, input logic fs, input logic [5:0] exp);
        @(negedge clk);
        colPos = 10'(col); rowPos = 10'(row); on = onv; pix_valid = 1'b1; frame_start = fs;
        @(negedge clk);
        pix_valid = 1'b0; frame_start = 1'b0;
        check1({tag, "_lat1_valid"}, color_valid, 1'b0);
        @(negedge clk);
        check1({tag, "_valid"}, color_valid, 1'b1);
        check6({tag, "_color"}, color, exp);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); frame_start = 1'b1;
            @(negedge clk); frame_start = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; freeze = 1'b0; pix_valid = 1'b0;
        on = 1'b1; colPos = '0; rowPos = '0;
        repeat (3) @(negedge clk);
        check6("reset_color", color, BLACK);
        check1("reset_valid", color_valid, 1'b0);
        rst_n = 1'b1;

        check_pix("grass_96_224", 96, 224, 1'b1, 1'b0, 6'b010001);
        check_pix("grass_p100",  100, 448, 1'b1, 1'b0, 6'b010001);
        check_pix("grass_p010",  104, 448, 1'b1, 1'b0, 6'b010000);
        check_pix("grass_p001",  112, 448, 1'b1, 1'b0, 6'b100000);
        check_pix("grass_p011",  120, 448, 1'b1, 1'b0, 6'b100000);
        check_pix("grass_p101",  116, 448, 1'b1, 1'b0, 6'b010000);
        check_pix("end_p000",     96,   0, 1'b1, 1'b0, 6'b001000);
        check_pix("end_p001",    112,   0, 1'b1, 1'b0, 6'b001001);
        check_pix("end_p010",    104,   0, 1'b1, 1'b0, 6'b011000);
        check_pix("end_p011",    120,   0, 1'b1, 1'b0, 6'b110001);
        check_pix("end_p100",    100,   0, 1'b1, 1'b0, 6'b011110);
        check_pix("end_p101",    116,   0, 1'b1, 1'b0, 6'b001000);
        check_pix("end_p110",    108,   0, 1'b1, 1'b0, 6'b001000);
        check_pix("end_p111",    124,   0, 1'b1, 1'b0, 6'b110001);
        check_pix("col544",      544,  32, 1'b1, 1'b0, BLACK);
        check_pix("col95",        95,   0, 1'b1, 1'b0, BLACK);
        check_pix("river_c543",  543,  32, 1'b1, 1'b0, BLUE);
        check_pix("river_r223",  144, 223, 1'b1, 1'b0, BLUE);
        check_pix("blk8_black",  200, 256, 1'b1, 1'b0, BLACK);
        check_pix("off_end",      96,   0, 1'b0, 1'b0, BLACK);
        check_pix("off_grass",    96, 224, 1'b0, 1'b0, BLACK);
        check_pix("off_river",   144,  32, 1'b0, 1'b0, BLACK);

        // Mid-stream asynchronous reset
        @(negedge clk);
        colPos = 10'd96; rowPos = 10'd224; on = 1'b1; pix_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check1("stream_valid", color_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check6("midreset_color", color, BLACK);
        check1("midreset_valid", color_valid, 1'b0);
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_pix("post_reset", 96, 224, 1'b1, 1'b0, 6'b010001);

        // Water animation
        check_pix("water_ph0", 144, 32, 1'b1, 1'b0, W_PH0);
        pulses(8);
        check_pix("water_ph1", 144, 32, 1'b1, 1'b0, W_PH1);
        pulses(56);
        check_pix("water_wrap", 144, 32, 1'b1, 1'b0, W_PH0);
        freeze = 1'b1;
        pulses(20);
        check_pix("water_frozen", 144, 32, 1'b1, 1'b0, W_PH0);
        freeze = 1'b0;
        pulses(7);
        check_pix("water_coincident", 144, 32, 1'b1, 1'b1, W_PH0);
        check_pix("water_after_pulse", 144, 32, 1'b1, 1'b0, W_PH1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
